// File: rtl/opl_ingress_arbiter_if.sv
// AXI4-Stream bundle used by the ingress arbiter: one instance per receive
// queue and one for the merged stream toward the lookup pipeline.
interface opl_ingress_arbiter_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/opl_ingress_arbiter.sv
// Packet-granular round-robin arbiter merging four RX queues into the lookup
// ingress stream. Per-queue packet counters exist only with OPL_ARB_PKT_COUNT_EN.
module opl_ingress_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES           = 4
) (
    input  logic                         AXI_ACLK,
    input  logic                         AXI_RESET,
    opl_ingress_arbiter_if.slave         s_axis_0,
    opl_ingress_arbiter_if.slave         s_axis_1,
    opl_ingress_arbiter_if.slave         s_axis_2,
    opl_ingress_arbiter_if.slave         s_axis_3,
    opl_ingress_arbiter_if.master        m_axis,
    output logic [31:0]                  pkt_count_0,
    output logic [31:0]                  pkt_count_1,
    output logic [31:0]                  pkt_count_2,
    output logic [31:0]                  pkt_count_3
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    state_t                             state_r, state_next_s;
    logic [1:0]                         grant_r, grant_next_s;
    logic [1:0]                         rr_ptr_r, rr_ptr_next_s;
    logic [1:0]                         pick_s, idx_s;
    logic                               pick_found_s;
    logic [NUM_QUEUES-1:0]              req_s;
    logic [NUM_QUEUES-1:0]              s_tready_s;
    logic                               beat_done_s;
    logic [C_S_AXIS_DATA_WIDTH-1:0]     sel_tdata_s;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]   sel_tstrb_s;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]    sel_tuser_s;
    logic                               sel_tvalid_s;
    logic                               sel_tlast_s;

    assign req_s = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};

    // First requesting queue at or after rr_ptr, wrapping modulo four
    always_comb begin
        pick_s       = rr_ptr_r;
        pick_found_s = 1'b0;
        idx_s        = rr_ptr_r;
        for (int i = 0; i < 4; i++) begin
            idx_s = rr_ptr_r + 2'(i);
            if (!pick_found_s && req_s[idx_s]) begin
                pick_s       = idx_s;
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Select the granted queue's beat
    always_comb begin
        sel_tdata_s  = {C_S_AXIS_DATA_WIDTH{1'b0}};
        sel_tstrb_s  = {(C_S_AXIS_DATA_WIDTH/8){1'b0}};
        sel_tuser_s  = {C_S_AXIS_TUSER_WIDTH{1'b0}};
        sel_tvalid_s = 1'b0;
        sel_tlast_s  = 1'b0;
        case (grant_r)
            2'd0: begin
                sel_tdata_s = s_axis_0.tdata; sel_tstrb_s = s_axis_0.tstrb; sel_tuser_s = s_axis_0.tuser;
                sel_tvalid_s = s_axis_0.tvalid; sel_tlast_s = s_axis_0.tlast;
            end
            2'd1: begin
                sel_tdata_s = s_axis_1.tdata; sel_tstrb_s = s_axis_1.tstrb; sel_tuser_s = s_axis_1.tuser;
                sel_tvalid_s = s_axis_1.tvalid; sel_tlast_s = s_axis_1.tlast;
            end
            2'd2: begin
                sel_tdata_s = s_axis_2.tdata; sel_tstrb_s = s_axis_2.tstrb; sel_tuser_s = s_axis_2.tuser;
                sel_tvalid_s = s_axis_2.tvalid; sel_tlast_s = s_axis_2.tlast;
            end
            2'd3: begin
                sel_tdata_s = s_axis_3.tdata; sel_tstrb_s = s_axis_3.tstrb; sel_tuser_s = s_axis_3.tuser;
                sel_tvalid_s = s_axis_3.tvalid; sel_tlast_s = s_axis_3.tlast;
            end
            default: begin
                sel_tvalid_s = 1'b0;
            end
        endcase
    end

    // Master mirrors the grant only in SEND; IDLE drives a quiet zero bus
    always_comb begin
        m_axis.tdata  = {C_M_AXIS_DATA_WIDTH{1'b0}};
        m_axis.tstrb  = {(C_M_AXIS_DATA_WIDTH/8){1'b0}};
        m_axis.tuser  = {C_M_AXIS_TUSER_WIDTH{1'b0}};
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        s_tready_s    = {NUM_QUEUES{1'b0}};
        if (state_r == ST_SEND) begin
            m_axis.tdata        = sel_tdata_s;
            m_axis.tstrb        = sel_tstrb_s;
            m_axis.tuser        = sel_tuser_s;
            m_axis.tvalid       = sel_tvalid_s;
            m_axis.tlast        = sel_tlast_s;
            s_tready_s[grant_r] = m_axis.tready;
        end else begin
            s_tready_s = {NUM_QUEUES{1'b0}};
        end
    end

    assign s_axis_0.tready = s_tready_s[0];
    assign s_axis_1.tready = s_tready_s[1];
    assign s_axis_2.tready = s_tready_s[2];
    assign s_axis_3.tready = s_tready_s[3];
    assign beat_done_s     = (state_r == ST_SEND) & sel_tvalid_s & m_axis.tready & sel_tlast_s;

    // Next-state: grant latched on entry to SEND, pointer advanced past it on TLAST
    always_comb begin
        state_next_s  = state_r;
        grant_next_s  = grant_r;
        rr_ptr_next_s = rr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_next_s = ST_SEND;
                    grant_next_s = pick_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (beat_done_s) begin
                    state_next_s  = ST_IDLE;
                    rr_ptr_next_s = grant_r + 2'd1;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            state_r  <= ST_IDLE;
            grant_r  <= 2'd0;
            rr_ptr_r <= 2'd0;
        end else begin
            state_r  <= state_next_s;
            grant_r  <= grant_next_s;
            rr_ptr_r <= rr_ptr_next_s;
        end
    end

`ifdef OPL_ARB_PKT_COUNT_EN
    logic [31:0] pkt_count_r [NUM_QUEUES];

    // Count accepted TLAST beats per queue, wrapping naturally at 2^32
    always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
        if (AXI_RESET) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                pkt_count_r[q] <= 32'd0;
            end
        end else if (beat_done_s) begin
            pkt_count_r[grant_r] <= pkt_count_r[grant_r] + 32'd1;
        end
    end

    assign pkt_count_0 = pkt_count_r[0];
    assign pkt_count_1 = pkt_count_r[1];
    assign pkt_count_2 = pkt_count_r[2];
    assign pkt_count_3 = pkt_count_r[3];
`else
    assign pkt_count_0 = 32'd0;
    assign pkt_count_1 = 32'd0;
    assign pkt_count_2 = 32'd0;
    assign pkt_count_3 = 32'd0;
`endif
endmodule

// File: tb/tb_opl_ingress_arbiter.sv
// Directed bench for opl_ingress_arbiter: single packet, round robin,
// backpressure, mid-packet stall and mid-packet reset.
module tb_opl_ingress_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    opl_ingress_arbiter_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s0 (), s1 (), s2 (), s3 (), m ();

    logic [255:0] s_tdata [4];
    logic [31:0]  s_tstrb [4];
    logic [127:0] s_tuser [4];
    logic [3:0]   s_tvalid, s_tlast;
    logic         m_tready;
    logic [31:0]  cnt0, cnt1, cnt2, cnt3;
    wire  [3:0]   s_tready = {s3.tready, s2.tready, s1.tready, s0.tready};

    assign s0.tdata = s_tdata[0]; assign s0.tstrb = s_tstrb[0]; assign s0.tuser = s_tuser[0];
    assign s0.tvalid = s_tvalid[0]; assign s0.tlast = s_tlast[0];
    assign s1.tdata = s_tdata[1]; assign s1.tstrb = s_tstrb[1]; assign s1.tuser = s_tuser[1];
    assign s1.tvalid = s_tvalid[1]; assign s1.tlast = s_tlast[1];
    assign s2.tdata = s_tdata[2]; assign s2.tstrb = s_tstrb[2]; assign s2.tuser = s_tuser[2];
    assign s2.tvalid = s_tvalid[2]; assign s2.tlast = s_tlast[2];
    assign s3.tdata = s_tdata[3]; assign s3.tstrb = s_tstrb[3]; assign s3.tuser = s_tuser[3];
    assign s3.tvalid = s_tvalid[3]; assign s3.tlast = s_tlast[3];
    assign m.tready = m_tready;

    opl_ingress_arbiter dut (
        .AXI_ACLK(clk), .AXI_RESET(rst),
        .s_axis_0(s0), .s_axis_1(s1), .s_axis_2(s2), .s_axis_3(s3), .m_axis(m),
        .pkt_count_0(cnt0), .pkt_count_1(cnt1), .pkt_count_2(cnt2), .pkt_count_3(cnt3)
    );

    int checks = 0;
    int failures = 0;
    bit en [4];
    bit pause [4];
    bit once [4];
    int len [4];
    int beat [4];
    int pkt [4];

    function automatic logic [255:0] mk_data(int q, int p, int b);
        return {224'd0, 32'((q << 16) | (p << 8) | b)};
    endfunction
    function automatic logic [127:0] mk_user(int q, int p, int b);
        return {96'd0, 32'hA500_0000 | 32'((b << 12) | (p << 4) | q)};
    endfunction
    function automatic logic [31:0] mk_strb(int b);
        return 32'hFFFF_FFFF >> b;
    endfunction
    function automatic logic [31:0] cexp(int n);
`ifdef OPL_ARB_PKT_COUNT_EN
        return 32'(n);
`else
        return 32'd0 & 32'(n);
`endif
    endfunction

    task automatic drive();
        for (int q = 0; q < 4; q++) begin
            s_tvalid[q] = en[q] & ~pause[q];
            s_tlast[q]  = (beat[q] == len[q] - 1);
            s_tdata[q]  = mk_data(q, pkt[q], beat[q]);
            s_tstrb[q]  = mk_strb(beat[q]);
            s_tuser[q]  = mk_user(q, pkt[q], beat[q]);
        end
    endtask

    task automatic clear_srcs();
        for (int q = 0; q < 4; q++) begin
            en[q] = 1'b0; pause[q] = 1'b0; once[q] = 1'b0;
            len[q] = 1; beat[q] = 0; pkt[q] = 0;
        end
    endtask

    task automatic set_src(int q, int l, bit o);
        en[q] = 1'b1; len[q] = l; once[q] = o; beat[q] = 0;
    endtask

    // One clock: handshakes seen before the edge advance the sources after it
    task automatic cyc();
        logic [3:0] hs;
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int q = 0; q < 4; q++) begin
            if (hs[q]) begin
                if (s_tlast[q]) begin
                    beat[q] = 0;
                    pkt[q]  = pkt[q] + 1;
                    if (once[q]) en[q] = 1'b0;
                end else begin
                    beat[q] = beat[q] + 1;
                end
            end
        end
        drive();
        #1;
    endtask

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(string tag, int q, int p, int b, bit last);
        chk({tag, ".valid"}, {255'd0, m.tvalid}, 256'd1);
        chk({tag, ".data"},  m.tdata, mk_data(q, p, b));
        chk({tag, ".strb"},  {224'd0, m.tstrb}, {224'd0, mk_strb(b)});
        chk({tag, ".user"},  {128'd0, m.tuser}, {128'd0, mk_user(q, p, b)});
        chk({tag, ".last"},  {255'd0, m.tlast}, {255'd0, last});
    endtask

    initial begin
        clear_srcs();
        m_tready = 1'b1;
        rst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        chk("rst.valid", {255'd0, m.tvalid}, 256'd0);
        chk("rst.tready", {252'd0, s_tready}, 256'd0);
        chk("rst.last", {255'd0, m.tlast}, 256'd0);
        chk("rst.data", m.tdata, 256'd0);
        chk("rst.cnt", {128'd0, cnt3, cnt2, cnt1, cnt0}, 256'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single 3-beat packet from queue 2
        set_src(2, 3, 1'b1);
        drive();
        #1;
        chk("p1.arb_wait", {255'd0, m.tvalid}, 256'd0);
        cyc();
        chk("p1.tready", {252'd0, s_tready}, 256'd4);
        chk_beat("p1.b0", 2, 0, 0, 1'b0);
        cyc();
        chk_beat("p1.b1", 2, 0, 1, 1'b0);
        cyc();
        chk_beat("p1.b2", 2, 0, 2, 1'b1);
        cyc();
        chk("p1.idle", {255'd0, m.tvalid}, 256'd0);
        chk("p1.idle_rdy", {252'd0, s_tready}, 256'd0);
        chk("p1.cnt2", {224'd0, cnt2}, {224'd0, cexp(1)});

        // Reset between tests so round robin starts from queue 0
        rst = 1'b1;
        clear_srcs();
        drive();
        @(negedge clk);
        rst = 1'b0;
        for (int q = 0; q < 4; q++) set_src(q, 2, 1'b0);
        drive();
        #1;
        cyc();
        for (int k = 0; k < 8; k++) begin
            chk("rr.grant", {252'd0, s_tready}, 256'(4'b0001 << (k % 4)));
            chk_beat("rr.b0", k % 4, k / 4, 0, 1'b0);
            cyc();
            chk_beat("rr.b1", k % 4, k / 4, 1, 1'b1);
            cyc();
            chk("rr.bubble", {255'd0, m.tvalid}, 256'd0);
            if (k < 7) cyc();
        end
        for (int q = 0; q < 4; q++) en[q] = 1'b0;
        drive();
        #1;
        chk("rr.cnt", {128'd0, cnt3, cnt2, cnt1, cnt0}, {128'd0, cexp(2), cexp(2), cexp(2), cexp(2)});

        // Backpressure on a 4-beat packet from queue 1, ready toggling 1,0,1,0
        set_src(1, 4, 1'b1);
        drive();
        #1;
        cyc();
        for (int j = 0; j < 7; j++) begin
            m_tready = (j % 2 == 0);
            #1;
            chk("bp.tready", {252'd0, s_tready}, {252'd0, 2'b00, m_tready, 1'b0});
            chk_beat("bp.beat", 1, 2, (j + 1) / 2, ((j + 1) / 2) == 3);
            cyc();
        end
        m_tready = 1'b1;
        #1;
        chk("bp.idle", {255'd0, m.tvalid}, 256'd0);
        chk("bp.cnt1", {224'd0, cnt1}, {224'd0, cexp(3)});

        // Queue 3 stalls mid-packet while queue 0 waits
        set_src(3, 4, 1'b1);
        drive();
        #1;
        cyc();
        chk("st.grant", {252'd0, s_tready}, 256'd8);
        chk_beat("st.b0", 3, 2, 0, 1'b0);
        cyc();
        pause[3] = 1'b1;
        set_src(0, 1, 1'b1);
        drive();
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("st.hold_valid", {255'd0, m.tvalid}, 256'd0);
            chk("st.hold_grant", {252'd0, s_tready}, 256'd8);
            cyc();
        end
        pause[3] = 1'b0;
        drive();
        #1;
        chk_beat("st.b1", 3, 2, 1, 1'b0);
        cyc();
        chk_beat("st.b2", 3, 2, 2, 1'b0);
        cyc();
        chk_beat("st.b3", 3, 2, 3, 1'b1);
        cyc();
        chk("st.bubble", {255'd0, m.tvalid}, 256'd0);
        cyc();
        chk("st.q0_grant", {252'd0, s_tready}, 256'd1);
        chk_beat("st.q0", 0, 2, 0, 1'b1);
        cyc();
        chk("st.idle", {255'd0, m.tvalid}, 256'd0);
        chk("st.cnt", {192'd0, cnt3, cnt0}, {192'd0, cexp(3), cexp(3)});

        // Reset on beat 2 of a 4-beat packet from queue 2
        set_src(2, 4, 1'b1);
        drive();
        #1;
        cyc();
        chk("rm.grant", {252'd0, s_tready}, 256'd4);
        cyc();
        cyc();
        chk_beat("rm.b2", 2, 2, 2, 1'b0);
        rst = 1'b1;
        #1;
        chk("rm.valid", {255'd0, m.tvalid}, 256'd0);
        chk("rm.tready", {252'd0, s_tready}, 256'd0);
        chk("rm.cnt", {128'd0, cnt3, cnt2, cnt1, cnt0}, 256'd0);
        clear_srcs();
        drive();
        @(negedge clk);
        rst = 1'b0;
        set_src(0, 1, 1'b1);
        set_src(3, 1, 1'b1);
        drive();
        #1;
        cyc();
        chk("rm.first_grant", {252'd0, s_tready}, 256'd1);
        chk_beat("rm.q0", 0, 0, 0, 1'b1);
        cyc();
        chk("rm.bubble", {255'd0, m.tvalid}, 256'd0);
        cyc();
        chk("rm.second_grant", {252'd0, s_tready}, 256'd8);
        chk_beat("rm.q3", 3, 0, 0, 1'b1);
        cyc();
        chk("rm.idle", {255'd0, m.tvalid}, 256'd0);
        chk("rm.cnt_after", {128'd0, cnt3, cnt2, cnt1, cnt0},
            {128'd0, cexp(1), 32'd0, 32'd0, cexp(1)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
